// File: rtl/hall_pkg.sv
// Shared definitions for the hall sensor front-end.
// Contents:
//   NUM_SECTORS    - number of commutation sectors per electrical revolution
//   SECTOR_INVALID - sector value returned for the illegal codes 000 / 111
//   delta_e        - classification of a sector-to-sector transition
//   hall_to_sector - hall code {A,B,C} -> sector 0..5 (or SECTOR_INVALID)
//   sector_delta   - classify old -> new sector as none / forward / reverse / skip
package hall_pkg;

    localparam int         NUM_SECTORS    = 6;
    localparam logic [2:0] SECTOR_INVALID = 3'b111;

    typedef enum logic [1:0] {
        DELTA_NONE,
        DELTA_FWD,
        DELTA_REV,
        DELTA_SKIP
    } delta_e;

    function automatic logic [2:0] hall_to_sector(input logic [2:0] hall);
        logic [2:0] sec;
        case (hall)
            3'b101:  sec = 3'd0;
            3'b100:  sec = 3'd1;
            3'b110:  sec = 3'd2;
            3'b010:  sec = 3'd3;
            3'b011:  sec = 3'd4;
            3'b001:  sec = 3'd5;
            default: sec = SECTOR_INVALID;
        endcase
        return sec;
    endfunction

    // Both arguments must be legal sectors (0..5).
    function automatic delta_e sector_delta(input logic [2:0] old_s, input logic [2:0] new_s);
        logic [3:0] diff;
        delta_e     res;
        // (new - old) mod 6, kept non-negative by adding 6 first
        diff = {1'b0, new_s} + 4'(NUM_SECTORS) - {1'b0, old_s};
        if (diff >= 4'(NUM_SECTORS)) begin
            diff = diff - 4'(NUM_SECTORS);
        end
        case (diff)
            4'd0:                  res = DELTA_NONE;
            4'd1:                  res = DELTA_FWD;
            4'(NUM_SECTORS - 1):   res = DELTA_REV;
            default:               res = DELTA_SKIP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// Synchroniser and debouncer for the three raw hall inputs.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   hall_async_i     - raw hall code {A,B,C}, asynchronous to clock
//   code_o           - accepted (debounced) hall code
//   code_changed_o   - one-cycle strobe when code_o takes a new value
//                      (also fires for the first accepted code after reset)
module hall_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] hall_async_i,
    output logic [2:0] code_o,
    output logic       code_changed_o
);
    import hall_pkg::*;

    localparam logic [15:0] DEB = 16'(DEBOUNCE_CYCLES);

    logic [2:0]  sync1_q, sync2_q;
    logic [1:0]  vld_q;
    logic [2:0]  cand_q, cand_d;
    logic [15:0] stab_q, stab_d;
    logic [2:0]  code_q, code_d;
    logic        acc_valid_q, acc_valid_d;
    logic        changed_q, changed_d;

    // stab_d counts consecutive cycles sync2 has held its value, including
    // the current one, so a code is accepted on the cycle the count reaches DEB.
    // vld_q keeps the post-reset contents of the synchroniser out of the count.
    always_comb begin
        cand_d      = sync2_q;
        code_d      = code_q;
        acc_valid_d = acc_valid_q;
        changed_d   = 1'b0;
        if (!vld_q[1]) begin
            stab_d = '0;
        end else if (sync2_q != cand_q) begin
            stab_d = 16'd1;
        end else if (stab_q == DEB) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 16'd1;
        end
        if (stab_d == DEB && (!acc_valid_q || sync2_q != code_q)) begin
            code_d      = sync2_q;
            acc_valid_d = 1'b1;
            changed_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            vld_q       <= '0;
            cand_q      <= '0;
            stab_q      <= '0;
            code_q      <= '0;
            acc_valid_q <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            sync1_q     <= hall_async_i;
            sync2_q     <= sync1_q;
            vld_q       <= {vld_q[0], 1'b1};
            cand_q      <= cand_d;
            stab_q      <= stab_d;
            code_q      <= code_d;
            acc_valid_q <= acc_valid_d;
            changed_q   <= changed_d;
        end
    end

    assign code_o         = code_q;
    assign code_changed_o = changed_q;

endmodule

// File: rtl/hall_speed_estimator.sv
// Hall sensor front-end: decodes the debounced hall code into a sector and
// derives direction, position count, step period and stall status.
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   hall_sensor1..3              - raw hall A/B/C inputs (asynchronous)
//   clear_count                  - zero position_count and skip_error
//   sector, sector_valid         - last legal sector / current code is legal
//   direction                    - 1 = forward, 0 = reverse
//   position_count               - signed step count, wraps
//   step_period, period_valid    - cycles between last two steps, update pulse
//   stalled                      - no step for TIMEOUT_CYCLES
//   hall_error, skip_error       - illegal code level / sticky sector skip
module hall_speed_estimator #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PERIOD_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES  = 25000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    hall_sensor1,
    input  logic                    hall_sensor2,
    input  logic                    hall_sensor3,
    input  logic                    clear_count,
    output logic [2:0]              sector,
    output logic                    sector_valid,
    output logic                    direction,
    output logic signed [31:0]      position_count,
    output logic [PERIOD_WIDTH-1:0] step_period,
    output logic                    period_valid,
    output logic                    stalled,
    output logic                    hall_error,
    output logic                    skip_error
);
    import hall_pkg::*;

    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_VAL = PERIOD_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] ALL_ONES    = '1;

    logic [2:0] code;
    logic       code_chg;

    hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock          (clock),
        .reset          (reset),
        .hall_async_i   ({hall_sensor1, hall_sensor2, hall_sensor3}),
        .code_o         (code),
        .code_changed_o (code_chg)
    );

    logic [2:0]              sector_q, sector_d;
    logic                    svalid_q, svalid_d;
    logic                    dir_q, dir_d;
    logic [31:0]             pos_q, pos_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    pvalid_q, pvalid_d;
    logic                    stalled_q, stalled_d;
    logic                    herr_q, herr_d;
    logic                    skip_q, skip_d;
    logic                    init_q, init_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]              new_sec;
    logic                    step, restart;

    always_comb begin
        sector_d  = sector_q;
        svalid_d  = svalid_q;
        dir_d     = dir_q;
        pos_d     = pos_q;
        period_d  = period_q;
        pvalid_d  = 1'b0;
        stalled_d = stalled_q;
        herr_d    = herr_q;
        skip_d    = skip_q;
        init_d    = init_q;
        step      = 1'b0;
        restart   = 1'b0;
        cnt_inc   = (cnt_q == ALL_ONES) ? cnt_q : cnt_q + 1'b1;
        cnt_d     = cnt_inc;
        new_sec   = hall_to_sector(code);

        if (code_chg) begin
            if (new_sec == SECTOR_INVALID) begin
                herr_d   = 1'b1;
                svalid_d = 1'b0;
            end else begin
                herr_d   = 1'b0;
                svalid_d = 1'b1;
                if (!init_q) begin
                    sector_d = new_sec;
                    init_d   = 1'b1;
                end else begin
                    case (sector_delta(sector_q, new_sec))
                        DELTA_FWD: begin
                            dir_d    = 1'b1;
                            pos_d    = pos_q + 32'd1;
                            sector_d = new_sec;
                            step     = 1'b1;
                        end
                        DELTA_REV: begin
                            dir_d    = 1'b0;
                            pos_d    = pos_q - 32'd1;
                            sector_d = new_sec;
                            step     = 1'b1;
                        end
                        DELTA_SKIP: begin
                            skip_d   = 1'b1;
                            sector_d = new_sec;
                            restart  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end

        // The first step out of a stall only re-arms the timer: the interval
        // it closes started before the stall and is not a usable measurement.
        if (step) begin
            restart = 1'b1;
            if (stalled_q) begin
                stalled_d = 1'b0;
            end else begin
                period_d = cnt_inc;
                pvalid_d = 1'b1;
            end
        end

        if (restart) begin
            cnt_d = '0;
        end else if (!stalled_q && cnt_inc == TIMEOUT_VAL) begin
            stalled_d = 1'b1;
            period_d  = ALL_ONES;
        end

        if (clear_count) begin
            pos_d  = '0;
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sector_q  <= '0;
            svalid_q  <= 1'b0;
            dir_q     <= 1'b0;
            pos_q     <= '0;
            period_q  <= ALL_ONES;
            pvalid_q  <= 1'b0;
            stalled_q <= 1'b1;
            herr_q    <= 1'b0;
            skip_q    <= 1'b0;
            init_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sector_q  <= sector_d;
            svalid_q  <= svalid_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            stalled_q <= stalled_d;
            herr_q    <= herr_d;
            skip_q    <= skip_d;
            init_q    <= init_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sector         = sector_q;
    assign sector_valid   = svalid_q;
    assign direction      = dir_q;
    assign position_count = pos_q;
    assign step_period    = period_q;
    assign period_valid   = pvalid_q;
    assign stalled        = stalled_q;
    assign hall_error     = herr_q;
    assign skip_error     = skip_q;

endmodule
